seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
- Accepts a packed BCD word plus per-digit decimal points through a single-cycle load strobe, and holds it in a shadow register.
- Commits the shadow register to the display register only at frame boundaries, so no frame ever shows a mix of old and new digits.
- Scans one digit at a time with a programmable dwell, and optionally suppresses leading zeros.
- Sits between the datapath (counters, calculators) and the board's anode/segment pins.

---
 rtl/seg7_scan_driver.sv | 189 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_scan_driver                                              |
// | Purpose  : Time-multiplexed driver for a DIGITS-wide common-anode        |
// |            7-segment display. Loads are held in a shadow register and    |
// |            committed only at frame boundaries; optional leading-zero     |
// |            suppression.                                                  |
// | Options  : HEX_DISPLAY_EN - when defined, codes 10..15 show A b C d E F; |
// |            otherwise those codes are blank.                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_blank,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  pending,
    output logic                  frame_tick
);

    localparam int c_PW = $clog2(SCAN_DIV);
    localparam int c_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(SCAN_DIV - 1);
    localparam logic [c_IW-1:0] c_IDX_LAST   = c_IW'(DIGITS - 1);

    // Active-high gfedcba segment pattern for one code; zero means all dark.
    function automatic logic [6:0] f_decode(input logic [3:0] code);
        logic [6:0] p;
        case (code)
            4'd0: p = 7'h3F;
            4'd1: p = 7'h06;
            4'd2: p = 7'h5B;
            4'd3: p = 7'h4F;
            4'd4: p = 7'h66;
            4'd5: p = 7'h6D;
            4'd6: p = 7'h7D;
            4'd7: p = 7'h07;
            4'd8: p = 7'h7F;
            4'd9: p = 7'h6F;
`ifdef HEX_DISPLAY_EN
            4'd10: p = 7'h77;
            4'd11: p = 7'h7C;
            4'd12: p = 7'h39;
            4'd13: p = 7'h5E;
            4'd14: p = 7'h79;
            4'd15: p = 7'h71;
`else
            default: p = 7'h00;
`endif
        endcase
        return p;
    endfunction

    logic [c_PW-1:0]     r_presc;
    logic [c_IW-1:0]     r_idx;
    logic [4*DIGITS-1:0] r_shadow_bcd;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [4*DIGITS-1:0] r_disp_bcd;
    logic [DIGITS-1:0]   r_disp_dp;
    logic                r_pending;
    logic                r_tick;
    logic [DIGITS-1:0]   r_an;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic                r_live;

    logic                w_term;
    logic                w_wrap;
    logic                w_upd;
    logic [c_IW-1:0]     w_idx_nxt;
    logic [4*DIGITS-1:0] w_disp_bcd_nxt;
    logic [DIGITS-1:0]   w_disp_dp_nxt;
    logic [3:0]          w_digit;
    logic                w_dp_bit;
    logic                w_blank;
    logic                w_allz;
    logic [DIGITS-1:0]   w_an_nxt;
    logic [6:0]          w_seg_nxt;

    assign w_term = (r_presc == c_PRESC_LAST);
    assign w_wrap = w_term && (r_idx == c_IDX_LAST);
    // Outputs refresh on each digit change, plus once right after reset so
    // digit 0 lights immediately instead of waiting a full dwell.
    assign w_upd  = w_term || !r_live;

    // Next-state index and display contents; a load on the wrap cycle goes
    // straight to the display so it is never lost in the shadow.
    always_comb begin
        w_idx_nxt      = r_idx;
        w_disp_bcd_nxt = r_disp_bcd;
        w_disp_dp_nxt  = r_disp_dp;
        if (w_term) begin
            w_idx_nxt = (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IW'(1);
        end
        if (w_wrap) begin
            w_disp_bcd_nxt = load ? bcd_in : r_shadow_bcd;
            w_disp_dp_nxt  = load ? dp_in  : r_shadow_dp;
        end
    end

    // Select the digit to show next and work out leading-zero blanking,
    // scanning from the most significant digit down.
    always_comb begin
        w_digit  = 4'd0;
        w_dp_bit = 1'b0;
        w_blank  = 1'b0;
        w_allz   = 1'b1;
        w_an_nxt = '1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_allz = w_allz & (w_disp_bcd_nxt[4*k +: 4] == 4'd0);
            if (w_idx_nxt == c_IW'(k)) begin
                w_digit     = w_disp_bcd_nxt[4*k +: 4];
                w_dp_bit    = w_disp_dp_nxt[k];
                w_blank     = lz_blank && (k != 0) && w_allz;
                w_an_nxt[k] = 1'b0;
            end
        end
        w_seg_nxt = w_blank ? 7'h7F : ~f_decode(w_digit);
    end

    // Prescaler and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_term ? '0 : r_presc + c_PW'(1);
            r_idx   <= w_idx_nxt;
        end
    end

    // Shadow capture, frame-boundary commit, pending flag and frame tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_bcd <= '0;
            r_shadow_dp  <= '0;
            r_disp_bcd   <= '0;
            r_disp_dp    <= '0;
            r_pending    <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            if (load) begin
                r_shadow_bcd <= bcd_in;
                r_shadow_dp  <= dp_in;
            end
            r_disp_bcd <= w_disp_bcd_nxt;
            r_disp_dp  <= w_disp_dp_nxt;
            if (w_wrap) begin
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
            r_tick <= w_wrap;
        end
    end

    // Registered pin drivers, updated together with the digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an   <= '1;
            r_seg  <= 7'h7F;
            r_dp   <= 1'b1;
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_upd) begin
                r_an  <= w_an_nxt;
                r_seg <= w_seg_nxt;
                r_dp  <= ~w_dp_bit;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign pending    = r_pending;
    assign frame_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seg7_scan_driver                                           |
// | Purpose  : Self-checking bench for seg7_scan_driver (DIGITS=4,           |
// |            SCAN_DIV=4) using a cycle-count reference model.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seg7_scan_driver;

    localparam int D = 4;
    localparam int S = 4;
    localparam int F = D * S;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        pending;
    logic        frame_tick;

    seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model state: cyc counts clock edges since reset release.
    int          cyc;
    logic [15:0] m_shadow, m_disp;
    logic [3:0]  m_dps, m_dpd;
    logic        m_pend, m_tick;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_dp;

    function automatic logic [6:0] pat(input logic [3:0] c);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
`ifdef HEX_DISPLAY_EN
              7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`else
              7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
`endif
        return t[c];
    endfunction

    // One clock edge: advance the model with the inputs as driven, then
    // compare every output a little after the edge.
    task automatic cycle();
        bit term, wrap, upd, blank;
        int k;
        @(posedge clk);
        if (rst) begin
            cyc = 0; m_shadow = 0; m_disp = 0; m_dps = 0; m_dpd = 0;
            m_pend = 0; m_tick = 0; m_an = 4'hF; m_seg = 7'h7F; m_dp = 1;
        end else begin
            term = (cyc % S) == S - 1;
            wrap = (cyc % F) == F - 1;
            upd  = term || (cyc == 0);
            if (load) begin m_shadow = bcd_in; m_dps = dp_in; end
            if (wrap) begin
                m_disp = m_shadow; m_dpd = m_dps; m_pend = 0;
            end else if (load) begin
                m_pend = 1;
            end
            m_tick = wrap;
            cyc++;
            if (upd) begin
                k     = (cyc / S) % D;
                m_an  = 4'hF;
                m_an[k] = 1'b0;
                blank = lz_blank && (k > 0) && ((m_disp >> (4 * k)) == 0);
                m_seg = blank ? 7'h7F : ~pat(m_disp[4*k +: 4]);
                m_dp  = ~m_dpd[k];
            end
        end
        #1;
        chk("an", 32'(an), 32'(m_an));
        chk("seg", 32'(seg), 32'(m_seg));
        chk("dp", 32'(dp), 32'(m_dp));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Advance until the model frame phase equals ph (bounded).
    task automatic run_to(input int ph);
        for (int i = 0; i < 2 * F && (cyc % F) != ph; i++) cycle();
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] d);
        load = 1'b1; bcd_in = b; dp_in = d;
        cycle();
        load = 1'b0;
    endtask

    logic [6:0] exp_a;

    initial begin
        rst = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0; lz_blank = 1'b0;
        cyc = 0;
        run(2);
        chk("rst_an", 32'(an), 32'h0000_000F);
        chk("rst_seg", 32'(seg), 32'h0000_007F);

        // Reset release: digit 0 lit showing '0', anodes rotate.
        rst = 1'b0;
        cycle();
        chk("first_an", 32'(an), 32'b1110);
        chk("first_seg", 32'(seg), 32'b1000000);
        run(2 * F);

        // Mid-frame load, committed at the next wrap.
        run_to(5);
        do_load(16'h1234, 4'b0010);
        chk("ld_pend", 32'(pending), 32'd1);
        run_to(0);
        chk("ld_tick", 32'(frame_tick), 32'd1);
        chk("ld_seg0", 32'(seg), 32'b0011001);
        run_to(4);
        chk("ld_dp1", 32'(dp), 32'd0);
        run(F);

        // Leading-zero suppression.
        lz_blank = 1'b1;
        do_load(16'h0070, 4'b0000);
        run_to(0);
        run_to(12);
        chk("lz_d3", 32'(seg), 32'h7F);
        do_load(16'h0000, 4'b0000);
        run_to(0);
        chk("lz0_d0", 32'(seg), 32'b1000000);
        run_to(4);
        chk("lz0_d1", 32'(seg), 32'h7F);
        lz_blank = 1'b0;

        // Load exactly on the wrap cycle.
        run_to(F - 1);
        do_load(16'h9999, 4'b0000);
        chk("wrap_pend", 32'(pending), 32'd0);
        chk("wrap_seg", 32'(seg), 32'b0010000);
        run(3);

        // Two loads before a wrap: the second wins.
        do_load(16'h1111, 4'b0001);
        do_load(16'h2222, 4'b0000);
        run_to(0);
        chk("two_seg", 32'(seg), 32'b0100100);

        // Hex code on digit 0.
        do_load(16'h000A, 4'b0000);
        run_to(0);
`ifdef HEX_DISPLAY_EN
        exp_a = ~7'h77;
`else
        exp_a = 7'h7F;
`endif
        chk("hex_a", 32'(seg), 32'(exp_a));

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            load     = ($urandom_range(0, 3) == 0);
            bcd_in   = 16'($urandom);
            dp_in    = 4'($urandom);
            if ($urandom_range(0, 19) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 2) == 0) bcd_in[15:8] = 8'h00;
            cycle();
        end
        load = 1'b0;

        // Reset mid-pending, with a load in the reset cycle discarded.
        run_to(6);
        do_load(16'h5678, 4'b1111);
        rst = 1'b1; load = 1'b1; bcd_in = 16'h4321;
        cycle();
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_pend", 32'(pending), 32'd0);
        rst = 1'b0; load = 1'b0;
        run(2 * F);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
